// File: rtl/serial_to_par_n_pkg.sv
// Shared types and constants for the multi-lane
// serial-to-parallel converter.
package serial_to_par_n_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    SYNC   = 2'd1,
    ACTIVE = 2'd2
  } lane_state_t;

  localparam logic [7:0] DEF_COM_SYM  = 8'hBC;
  localparam logic [7:0] DEF_IDLE_SYM = 8'h7C;

endpackage

// File: rtl/s2p_lane.sv
// One deserialiser lane: shift register, bit and
// COM counters, and the SEARCH/SYNC/ACTIVE lock FSM.
module s2p_lane
  import serial_to_par_n_pkg::*;
#(
  parameter int              WIDTH     = 8,
  parameter int              COM_COUNT = 4,
  parameter logic [WIDTH-1:0] COM_SYM  = WIDTH'(DEF_COM_SYM),
  parameter logic [WIDTH-1:0] IDLE_SYM = WIDTH'(DEF_IDLE_SYM),
  parameter int              MSB_FIRST = 1
) (
  input  logic             clk_8f,
  input  logic             reset_L,
  input  logic             bit_in,
  input  logic             realign,
  output logic [WIDTH-1:0] word,
  output logic             valid,
  output logic             active
);

  localparam int BW = $clog2(WIDTH);
  localparam int CW = (COM_COUNT > 1) ? $clog2(COM_COUNT) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
  localparam logic [CW-1:0] LAST_COM = CW'(COM_COUNT - 1);

  lane_state_t      state, state_n;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] nxt;
  logic [BW-1:0]    bit_cnt, bit_n;
  logic [CW-1:0]    com_cnt, com_n;
  logic [WIDTH-1:0] word_n;
  logic             valid_n;
  logic             boundary;

  assign nxt = (MSB_FIRST != 0) ? {sr[WIDTH-2:0], bit_in}
                                : {bit_in, sr[WIDTH-1:1]};

  assign boundary = (bit_cnt == LAST_BIT);

  // Shift register runs every cycle regardless of lock state.
  always_ff @(posedge clk_8f or negedge reset_L) begin
    if (!reset_L) sr <= '0;
    else          sr <= nxt;
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk_8f or negedge reset_L) begin
    if (!reset_L) begin
      state   <= SEARCH;
      bit_cnt <= '0;
      com_cnt <= '0;
      word    <= '0;
      valid   <= 1'b0;
      active  <= 1'b0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_n;
      com_cnt <= com_n;
      word    <= word_n;
      valid   <= valid_n;
      active  <= (state_n == ACTIVE);
    end
  end

  // Next-state: hunt for COM, confirm alignment, then emit words.
  always_comb begin
    state_n = state;
    com_n   = com_cnt;
    word_n  = word;
    valid_n = 1'b0;
    bit_n   = boundary ? '0 : bit_cnt + 1'b1;
    unique case (state)
      SEARCH: begin
        bit_n = '0;
        if (nxt == COM_SYM) begin
          if (COM_COUNT == 1) begin
            state_n = ACTIVE;
            com_n   = '0;
          end else begin
            state_n = SYNC;
            com_n   = CW'(1);
          end
        end
      end
      SYNC: begin
        if (boundary) begin
          if (nxt == COM_SYM) begin
            if (com_cnt == LAST_COM) begin
              state_n = ACTIVE;
              com_n   = '0;
            end else begin
              com_n = com_cnt + 1'b1;
            end
          end else begin
            state_n = SEARCH;
            com_n   = '0;
          end
        end
      end
      ACTIVE: begin
        if (boundary) begin
          word_n  = nxt;
          valid_n = (nxt != COM_SYM) && (nxt != IDLE_SYM);
        end
      end
      default: begin
        state_n = SEARCH;
        com_n   = '0;
        bit_n   = '0;
      end
    endcase
    if (realign) begin
      state_n = SEARCH;
      com_n   = '0;
      bit_n   = '0;
      valid_n = 1'b0;
      word_n  = word;
    end
  end

endmodule

// File: rtl/serial_to_par_n.sv
// Multi-lane serial-to-parallel converter with
// per-lane COM alignment and word valid strobes.
module serial_to_par_n
  import serial_to_par_n_pkg::*;
#(
  parameter int              WIDTH     = 8,
  parameter int              NUM_LANES = 2,
  parameter int              COM_COUNT = 4,
  parameter logic [WIDTH-1:0] COM_SYM  = WIDTH'(DEF_COM_SYM),
  parameter logic [WIDTH-1:0] IDLE_SYM = WIDTH'(DEF_IDLE_SYM),
  parameter int              MSB_FIRST = 1
) (
  input  logic                       clk_8f,
  input  logic                       reset_L,
  input  logic [NUM_LANES-1:0]       data_in,
  input  logic                       realign,
  output logic [NUM_LANES*WIDTH-1:0] data_out,
  output logic [NUM_LANES-1:0]       valid_out,
  output logic [NUM_LANES-1:0]       active
);

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    s2p_lane #(
      .WIDTH    (WIDTH),
      .COM_COUNT(COM_COUNT),
      .COM_SYM  (COM_SYM),
      .IDLE_SYM (IDLE_SYM),
      .MSB_FIRST(MSB_FIRST)
    ) u_lane (
      .clk_8f (clk_8f),
      .reset_L(reset_L),
      .bit_in (data_in[i]),
      .realign(realign),
      .word   (data_out[i*WIDTH +: WIDTH]),
      .valid  (valid_out[i]),
      .active (active[i])
    );
  end

endmodule
